// File: rtl/cpu_defs.sv
// Shared CPU definitions for the fetch/decode boundary.
// Exception codes are the {IADEE,IADFE} pair carried with each word.
package cpu_defs;

    localparam int          DW       = 32;
    localparam logic [1:0]  EXC_NONE = 2'b00;
    localparam logic [1:0]  EXC_ADEF = 2'b01;
    localparam logic [1:0]  EXC_ADEE = 2'b10;
    localparam logic [31:0] NOP_INST = 32'h0;

endpackage

// File: rtl/inst_fetch_queue_ram.sv
// Instruction queue storage: two write ports, two async read ports.
// Storage is deliberately unreset; occupancy masks stale contents.
module ifq_ram_2w2r #(
    parameter int DEPTH = 8,
    parameter int W     = 66,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_0,
    input  logic [AW-1:0] waddr_0,
    input  logic [W-1:0]  wdata_0,
    input  logic          we_1,
    input  logic [AW-1:0] waddr_1,
    input  logic [W-1:0]  wdata_1,
    input  logic [AW-1:0] raddr_0,
    output logic [W-1:0]  rdata_0,
    input  logic [AW-1:0] raddr_1,
    output logic [W-1:0]  rdata_1
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_0) mem_q[waddr_0] <= wdata_0;
        if (we_1) mem_q[waddr_1] <= wdata_1;
    end

    assign rdata_0 = mem_q[raddr_0];
    assign rdata_1 = mem_q[raddr_1];

endmodule

// File: rtl/inst_fetch_queue.sv
// Decoupling queue between dual-fetch IF and dual-issue ID.
// Accepts up to two words per cycle, presents the two oldest entries.
module inst_fetch_queue #(
    parameter int DEPTH = 8,
    parameter int DW    = cpu_defs::DW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid_0,
    input  logic                     in_valid_1,
    input  logic [DW-1:0]            in_pc,
    input  logic [DW-1:0]            in_inst_0,
    input  logic [DW-1:0]            in_inst_1,
    input  logic [1:0]               in_exc,
    output logic                     in_ready,
    output logic                     out_valid_0,
    output logic                     out_valid_1,
    output logic [DW-1:0]            out_inst_0,
    output logic [DW-1:0]            out_inst_1,
    output logic [DW-1:0]            out_pc_0,
    output logic [DW-1:0]            out_pc_1,
    output logic [1:0]               out_exc_0,
    output logic [1:0]               out_exc_1,
    input  logic [1:0]               out_pop,
    output logic [$clog2(DEPTH):0]   count
);

    import cpu_defs::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * DW + 2;

    typedef struct packed {
        logic [DW-1:0] pc;
        logic [DW-1:0] inst;
        logic [1:0]    exc;
    } entry_t;

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          push_0, push_1;
    logic [CW-1:0] n_push;
    logic [1:0]    pop_req, pop_eff;
    entry_t        wr_ent_0, wr_ent_1;
    entry_t        rd_ent_0, rd_ent_1;

    always_comb begin
        in_ready = (count_q <= CW'(DEPTH - 2));
        push_0   = in_valid_0 && in_ready && !flush;
        push_1   = push_0 && in_valid_1;
        n_push   = CW'(push_0) + CW'(push_1);

        // ID never sees more than two entries, so clamp the request first
        pop_req = (out_pop > 2'd1) ? 2'd2 : out_pop;
        if (count_q == '0)
            pop_eff = 2'd0;
        else if (count_q == CW'(1) && pop_req != 2'd0)
            pop_eff = 2'd1;
        else
            pop_eff = pop_req;

        wr_ptr_d = wr_ptr_q + AW'(n_push);
        rd_ptr_d = rd_ptr_q + AW'(pop_eff);
        count_d  = count_q + n_push - CW'(pop_eff);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ent_0 = '{pc: in_pc, inst: in_inst_0, exc: in_exc};
    assign wr_ent_1 = '{pc: in_pc + DW'(4), inst: in_inst_1, exc: in_exc};

    ifq_ram_2w2r #(
        .DEPTH (DEPTH),
        .W     (EW),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_0    (push_0),
        .waddr_0 (wr_ptr_q),
        .wdata_0 (wr_ent_0),
        .we_1    (push_1),
        .waddr_1 (wr_ptr_q + AW'(1)),
        .wdata_1 (wr_ent_1),
        .raddr_0 (rd_ptr_q),
        .rdata_0 (rd_ent_0),
        .raddr_1 (rd_ptr_q + AW'(1)),
        .rdata_1 (rd_ent_1)
    );

    always_comb begin
        out_valid_0 = (count_q > CW'(0));
        out_valid_1 = (count_q > CW'(1));
        out_inst_0  = out_valid_0 ? rd_ent_0.inst : DW'(NOP_INST);
        out_inst_1  = out_valid_1 ? rd_ent_1.inst : DW'(NOP_INST);
        out_pc_0    = out_valid_0 ? rd_ent_0.pc : '0;
        out_pc_1    = out_valid_1 ? rd_ent_1.pc : '0;
        out_exc_0   = out_valid_0 ? rd_ent_0.exc : EXC_NONE;
        out_exc_1   = out_valid_1 ? rd_ent_1.exc : EXC_NONE;
        count       = count_q;
    end

endmodule
